branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Dynamic branch predictor and redirect controller for the 5-stage pipelined MIPS core. It holds a direct-mapped table of 2-bit saturating counters indexed by PC and predicts direction for branches in IF. It resolves the prediction against the real outcome in ID, trains the table, and drives the PC-select (`Branch`) and `IF_flush` controls consumed by the PC mux and the IF/ID register. The table initialises itself after reset; no reset fan-out goes to the array.

## Interface
- `IDX_W`, 6: table index width; 2^IDX_W entries, index = pc[IDX_W+1:2].
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: ID stage held this cycle; suppresses update and redirect.
- `OP_if` in 6: opcode of the instruction in IF.
- `pc_if` in 32: PC of the instruction in IF.
- `OP_id` in 6: opcode of the instruction in ID.
- `pc_id` in 32: PC of the instruction in ID.
- `pred_id` in 1: the `pred_if` value carried with this instruction through IF/ID.
- `taken_id` in 1: resolved outcome from the ID comparator.
- `Jump` in 2: jump control from the main decoder; 2'b01 = jump in ID.
- `pred_if` out 1: predicted taken for the IF instruction.
- `Branch` out 2: 00 = PC+4; 01 = predicted target; 10 = recover to branch target; 11 = recover to pc_id+4.
- `IF_flush` out 1: squash the IF/ID register.
- `ready` out 1: table initialised; top holds the pipeline while low.
- `br_cnt` out 32: resolved branches. Present only with BHT_STATS_EN.
- `miss_cnt` out 32: mispredicts. Present only with BHT_STATS_EN.

## Operation
- Branch opcodes: `OP_BEQ`, `OP_BNE`, `OP_BLEZ`, `OP_BGTZ`, and REGIMM (`OP_BLTZ`/`OP_BGEZ`, 6'b000001), all from the shared instruction defines.
- FSM states: INIT, RUN.
  - Reset enters INIT with ptr = 0.
  - Each INIT cycle writes entry[ptr] = 2'b01 (weakly not-taken), then ptr++.
  - INIT → RUN after writing entry 2^IDX_W−1.
  - RUN is terminal until reset.
- `ready` = (state == RUN).
- Prediction (RUN, combinational): `pred_if` = branch opcode in IF AND entry[pc_if idx][1]. Non-branch opcodes give `pred_if` = 0.
- Resolution event: RUN, branch opcode in ID, `stall` = 0.
- Update on a resolution event, at the clock edge:
  - `taken_id` = 1: entry saturating-increments toward 2'b11.
  - `taken_id` = 0: entry saturating-decrements toward 2'b00.
- Mispredict: resolution event AND `pred_id` != `taken_id`.
- `Branch` priority:
  1. Mispredict: 10 if `taken_id`, else 11.
  2. Otherwise, `pred_if` = 1: 01.
  3. Otherwise: 00.
- `IF_flush` = mispredict OR (`Jump` == 2'b01, regardless of state/stall except INIT).
- In INIT: `pred_if` = 0, `Branch` = 00, `IF_flush` = 0; no updates.
- Same-index read/write in one cycle: IF sees the pre-update value. No bypass.
- Aliasing is permitted. PCs with equal pc[IDX_W+1:2] share an entry.

## Timing
- Reset values: state INIT, ptr 0, `ready` 0, `pred_if` 0, `Branch` 00, `IF_flush` 0, counters 0.
- `ready` rises 2^IDX_W cycles after `rst_n` deassertion (64 for default).
- `pred_if`, `Branch`, and `IF_flush` are combinational, valid in the same cycle as their inputs.
- Table write takes effect on the edge ending the resolution cycle; visible to IF from the next cycle.
- `rst_n` asserted mid-INIT or mid-RUN aborts immediately: outputs take reset values and the sweep restarts at 0.
- With `stall` = 1 and a held mispredicting branch in ID, redirect fires in the first cycle `stall` = 0. Exactly one update occurs.

## Configuration
- `BHT_STATS_EN` defined:
  - `br_cnt` increments on every resolution event.
  - `miss_cnt` increments on every mispredict.
  - Both are 32-bit, wrap at 2^32, reset to 0, and are not cleared by INIT.
- `BHT_STATS_EN` undefined: both ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset, release `rst_n` → `ready` = 0 for exactly 64 cycles, then 1. First BEQ at `pc_if` = 0x40 gives `pred_if` = 0.
- BEQ in ID, `pc_id` = 0x40, `pred_id` = 0, `taken_id` = 1 → same cycle `IF_flush` = 1, `Branch` = 10. Next cycle, `pc_if` = 0x40 gives `pred_if` = 1. `pc_if` = 0x140 (aliased) also gives 1.
- Four taken resolutions at 0x80, then one not-taken (`pred_id` = 1) → not-taken cycle gives `Branch` = 11, `IF_flush` = 1. Entry reads 2'b10, so `pred_if` stays 1.
- Mispredict condition with `stall` = 1 for 3 cycles → `IF_flush` = 0, no table change. On `stall` = 0, flush for one cycle and one update.
- `Jump` = 2'b01, no branch in ID/IF → `IF_flush` = 1, `Branch` = 00. Same with `rst_n` pulsed low mid-run → outputs reset, `ready` low for 64 cycles.
- With `BHT_STATS_EN`: 10 resolutions with 3 mispredicts → `br_cnt` = 10, `miss_cnt` = 3. Preload near wrap (0xFFFFFFFF + 1) → 0.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//   Dynamic branch predictor and redirect controller for the 5-stage MIPS
//   pipeline. A direct-mapped table of 2-bit saturating counters, indexed by
//   pc[IDX_W+1:2], predicts branch direction in IF. The real outcome arrives
//   in ID. There the prediction is resolved, the table is trained, and the
//   PC-select / IF/ID flush controls are produced.
//
//   After reset the table is swept to "weakly not-taken" one entry per cycle.
//   The array itself is never reset.
//
// Optional feature macro: BHT_STATS_EN
//   Defining this macro adds the br_cnt / miss_cnt statistics counters and
//   their ports.
//
// Ports
//   clk        in   pipeline clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   stall      in   ID held this cycle; no table update, no mispredict redirect
//   OP_if      in   [5:0]  opcode of the IF instruction
//   pc_if      in   [31:0] PC of the IF instruction
//   OP_id      in   [5:0]  opcode of the ID instruction
//   pc_id      in   [31:0] PC of the ID instruction
//   pred_id    in   prediction carried with the ID instruction
//   taken_id   in   resolved branch outcome in ID
//   Jump       in   [1:0]  main-decoder jump control, 2'b01 = jump in ID
//   pred_if    out  predicted taken for the IF instruction
//   Branch     out  [1:0]  00 PC+4, 01 predicted target,
//                          10 recover to branch target, 11 recover to pc_id+4
//   IF_flush   out  squash the IF/ID register
//   ready      out  table initialised (FSM in RUN)
//   br_cnt     out  [31:0] resolved branches   (BHT_STATS_EN only)
//   miss_cnt   out  [31:0] mispredicts         (BHT_STATS_EN only)
//
// ready semantics: ready is a level, not a handshake. It is low from reset
//   until the last table entry has been written. It then stays high until
//   the next reset. While ready is low the enclosing core must hold the
//   pipeline. In that period this block issues no prediction, redirect or
//   flush.
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [5:0]  OP_if,
  input  logic [31:0] pc_if,
  input  logic [5:0]  OP_id,
  input  logic [31:0] pc_id,
  input  logic        pred_id,
  input  logic        taken_id,
  input  logic [1:0]  Jump,
  output logic        pred_if,
  output logic [1:0]  Branch,
  output logic        IF_flush,
  output logic        ready
`ifdef BHT_STATS_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  // Branch opcodes. REGIMM covers BLTZ/BGEZ.
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [1:0] WEAK_NT = 2'b01;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [1:0]        bht [ENTRIES];

  logic [IDX_W-1:0]  idx_if, idx_id;
  logic              run;
  logic              br_if, br_id;
  logic              resolve;
  logic              mispredict;
  logic [1:0]        cur_id;
  logic [1:0]        trained;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_widx;
  logic [1:0]        tbl_wdata;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
           (op == OP_BGTZ) || (op == OP_REGIMM);
  endfunction

  assign idx_if = pc_if[IDX_W+1:2];
  assign idx_id = pc_id[IDX_W+1:2];

  // The index only uses the word-address bits just above the byte offset.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[31:IDX_W+2], pc_if[1:0],
                            pc_id[31:IDX_W+2], pc_id[1:0]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) ptr_q <= ptr_q + 1'b1;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && ptr_q == {IDX_W{1'b1}}) state_d = RUN;
  end

  assign run   = (state_q == RUN);
  assign ready = run;

  // ---------------- resolution / training ----------------
  assign br_if      = is_branch(OP_if);
  assign br_id      = is_branch(OP_id);
  assign resolve    = run && br_id && !stall;
  assign mispredict = resolve && (pred_id != taken_id);
  assign cur_id     = bht[idx_id];

  always_comb begin
    trained = cur_id;
    if (taken_id) begin
      if (cur_id != 2'b11) trained = cur_id + 2'b01;
    end else begin
      if (cur_id != 2'b00) trained = cur_id - 2'b01;
    end
  end

  // Single write port. INIT sweeps the array. RUN trains on resolution.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_widx  = idx_id;
    tbl_wdata = trained;
    if (!run) begin
      tbl_we    = 1'b1;
      tbl_widx  = ptr_q;
      tbl_wdata = WEAK_NT;
    end else if (resolve) begin
      tbl_we    = 1'b1;
    end
  end

  // No reset on the array. The INIT sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (tbl_we) bht[tbl_widx] <= tbl_wdata;
  end

  // ---------------- outputs ----------------
  // The IF read sees the pre-update value on a same-index collision,
  // because there is no bypass from the write port.
  always_comb begin
    pred_if  = 1'b0;
    Branch   = 2'b00;
    IF_flush = 1'b0;
    if (run) begin
      pred_if  = br_if && bht[idx_if][1];
      IF_flush = mispredict || (Jump == 2'b01);
      if (mispredict)   Branch = taken_id ? 2'b10 : 2'b11;
      else if (pred_if) Branch = 2'b01;
    end
  end

`ifdef BHT_STATS_EN
  // Statistics survive the INIT sweep and are cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (resolve)    br_cnt   <= br_cnt + 32'd1;
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//   Self-checking bench for branch_predict_ctrl. Uses a table of per-cycle
//   vectors with hand-derived expected {pred_if, Branch, IF_flush}. Also has
//   sequences for init length, reset abort, and the statistics counters
//   (BHT_STATS_EN).
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

  localparam logic [5:0] NOP  = 6'b000000;
  localparam logic [5:0] RGM  = 6'b000001;
  localparam logic [5:0] JOP  = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] BLEZ = 6'b000110;
  localparam logic [5:0] BGTZ = 6'b000111;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic        stall, pred_id, taken_id;
  logic [5:0]  OP_if, OP_id;
  logic [31:0] pc_if, pc_id;
  logic [1:0]  Jump;
  logic        pred_if, IF_flush, ready;
  logic [1:0]  Branch;
`ifdef BHT_STATS_EN
  logic [31:0] br_cnt, miss_cnt;
`endif

  branch_predict_ctrl #(.IDX_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .OP_if    (OP_if),
    .pc_if    (pc_if),
    .OP_id    (OP_id),
    .pc_id    (pc_id),
    .pred_id  (pred_id),
    .taken_id (taken_id),
    .Jump     (Jump),
    .pred_if  (pred_if),
    .Branch   (Branch),
    .IF_flush (IF_flush),
    .ready    (ready)
`ifdef BHT_STATS_EN
    ,
    .br_cnt   (br_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0]  op_if;
    logic [31:0] pc_if;
    logic [5:0]  op_id;
    logic [31:0] pc_id;
    logic        pred_id;
    logic        taken_id;
    logic        stall;
    logic [1:0]  jump;
    logic        exp_pred;
    logic [1:0]  exp_br;
    logic        exp_fl;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [5:0] oi, input logic [31:0] pi,
                     input logic [5:0] od, input logic [31:0] pd,
                     input logic prd, input logic tkn, input logic stl,
                     input logic [1:0] jmp, input logic ep,
                     input logic [1:0] eb, input logic ef);
    vec_t v;
    v.op_if = oi; v.pc_if = pi; v.op_id = od; v.pc_id = pd;
    v.pred_id = prd; v.taken_id = tkn; v.stall = stl; v.jump = jmp;
    v.exp_pred = ep; v.exp_br = eb; v.exp_fl = ef;
    vecs.push_back(v);
  endtask

  task automatic set_inputs(input vec_t v);
    OP_if = v.op_if; pc_if = v.pc_if; OP_id = v.op_id; pc_id = v.pc_id;
    pred_id = v.pred_id; taken_id = v.taken_id; stall = v.stall;
    Jump = v.jump;
  endtask

  task automatic set_idle();
    OP_if = NOP; pc_if = 32'h0; OP_id = NOP; pc_id = 32'h0;
    pred_id = 1'b0; taken_id = 1'b0; stall = 1'b0; Jump = 2'b00;
  endtask

  task automatic check_out(input string name);
    logic [3:0] exp, got;
    got = {pred_if, Branch, IF_flush};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got pred/br/fl=%b", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got pred=%b br=%b fl=%b, expected pred=%b br=%b fl=%b",
                 name, got[3], got[2:1], got[0], exp[3], exp[2:1], exp[0]);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector after a rising edge and compare on the falling edge.
  task automatic run_vec(input vec_t v, input int n);
    @(posedge clk); #1;
    set_inputs(v);
    exp_q.push_back({v.exp_pred, v.exp_br, v.exp_fl});
    @(negedge clk);
    check_out($sformatf("vec%0d", n));
  endtask

  // Count rising edges from reset release until ready. The loop is bounded.
  task automatic count_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n_cyc;

  initial begin
    set_idle();
    rst_n = 1'b0;

    // ---- reset state: active inputs must be ignored ----
    OP_if = BEQ; pc_if = 32'h40; OP_id = BEQ; pc_id = 32'h40;
    pred_id = 1'b0; taken_id = 1'b1; Jump = 2'b01;
    #12;
    exp_q.push_back(4'b0000);
    check_out("reset_outs");
    check_val("reset_ready", {31'd0, ready}, 32'd0);
`ifdef BHT_STATS_EN
    check_val("reset_br_cnt", br_cnt, 32'd0);
    check_val("reset_miss_cnt", miss_cnt, 32'd0);
`endif

    // ---- INIT with Jump active still gives no flush; abort mid-INIT ----
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(4'b0000);
    check_out("init_outs");
    check_val("init_ready_low", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("init_abort_ready", {31'd0, ready}, 32'd0);
    set_idle();
    @(negedge clk); rst_n = 1'b1;
    count_ready(n_cyc);
    check_val("init_len", n_cyc, 32'd64);

    // ---- vector table ----
    //   op_if pc_if   op_id pc_id    prd tkn stl jmp   pred br    fl
    add(BEQ,  32'h40,  NOP,  32'h0,   0,  0,  0,  2'b00, 0, 2'b00, 0); // init weak NT
    add(NOP,  32'h0,   BEQ,  32'h40,  0,  1,  0,  2'b00, 0, 2'b10, 1); // mispredict taken
    add(BEQ,  32'h40,  NOP,  32'h0,   0,  0,  0,  2'b00, 1, 2'b01, 0); // entry now 10
    add(BNE,  32'h140, NOP,  32'h0,   0,  0,  0,  2'b00, 1, 2'b01, 0); // alias
    add(NOP,  32'h40,  NOP,  32'h0,   0,  0,  0,  2'b00, 0, 2'b00, 0); // non-branch IF
    add(NOP,  32'h0,   BEQ,  32'h80,  0,  1,  0,  2'b00, 0, 2'b10, 1); // 01->10
    add(NOP,  32'h0,   BEQ,  32'h80,  1,  1,  0,  2'b00, 0, 2'b00, 0); // 10->11
    add(NOP,  32'h0,   BEQ,  32'h80,  1,  1,  0,  2'b00, 0, 2'b00, 0); // sat 11
    add(NOP,  32'h0,   BEQ,  32'h80,  1,  1,  0,  2'b00, 0, 2'b00, 0); // sat 11
    add(BGTZ, 32'h80,  BEQ,  32'h80,  1,  0,  0,  2'b00, 1, 2'b11, 1); // NT recover, pre-update read
    add(BLEZ, 32'h80,  NOP,  32'h0,   0,  0,  0,  2'b00, 1, 2'b01, 0); // entry 10
    add(NOP,  32'h0,   RGM,  32'hC0,  0,  0,  0,  2'b00, 0, 2'b00, 0); // 01->00
    add(NOP,  32'h0,   RGM,  32'hC0,  0,  0,  0,  2'b00, 0, 2'b00, 0); // sat 00
    add(RGM,  32'hC0,  NOP,  32'h0,   0,  0,  0,  2'b00, 0, 2'b00, 0);
    add(NOP,  32'h0,   BNE,  32'hC0,  0,  1,  0,  2'b00, 0, 2'b10, 1); // 00->01
    add(BNE,  32'hC0,  NOP,  32'h0,   0,  0,  0,  2'b00, 0, 2'b00, 0); // still NT
    add(NOP,  32'h0,   JOP,  32'h0,   0,  0,  0,  2'b01, 0, 2'b00, 1); // jump flush
    add(NOP,  32'h0,   NOP,  32'h0,   0,  0,  0,  2'b10, 0, 2'b00, 0); // other Jump code
    add(NOP,  32'h0,   JOP,  32'h0,   0,  0,  1,  2'b01, 0, 2'b00, 1); // jump ignores stall
    add(BEQ,  32'h100, BEQ,  32'h100, 0,  1,  1,  2'b00, 0, 2'b00, 0); // stalled
    add(BEQ,  32'h100, BEQ,  32'h100, 0,  1,  1,  2'b00, 0, 2'b00, 0);
    add(BEQ,  32'h100, BEQ,  32'h100, 0,  1,  1,  2'b00, 0, 2'b00, 0);
    add(BEQ,  32'h100, BEQ,  32'h100, 0,  1,  0,  2'b00, 0, 2'b10, 1); // released: 01->10
    add(BEQ,  32'h100, NOP,  32'h0,   0,  0,  0,  2'b00, 1, 2'b01, 0);
    add(NOP,  32'h0,   BEQ,  32'h100, 1,  0,  0,  2'b00, 0, 2'b11, 1); // 10->01
    add(BEQ,  32'h100, NOP,  32'h0,   0,  0,  0,  2'b00, 0, 2'b00, 0); // one update only
    add(NOP,  32'h0,   NOP,  32'h0,   0,  1,  0,  2'b00, 0, 2'b00, 0); // non-branch in ID

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

`ifdef BHT_STATS_EN
    // 11 resolution events, 6 of them mispredicts, in the table above.
    check_val("br_cnt", br_cnt, 32'd11);
    check_val("miss_cnt", miss_cnt, 32'd6);
    @(negedge clk);
    force dut.br_cnt = 32'hFFFF_FFFF;
    force dut.miss_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt;
    release dut.miss_cnt;
    begin
      vec_t w;
      w.op_if = NOP; w.pc_if = 32'h0; w.op_id = BEQ; w.pc_id = 32'h200;
      w.pred_id = 1'b1; w.taken_id = 1'b0; w.stall = 1'b0; w.jump = 2'b00;
      w.exp_pred = 1'b0; w.exp_br = 2'b11; w.exp_fl = 1'b1;
      run_vec(w, 100);
    end
    @(posedge clk); #1;
    set_idle();
    check_val("br_cnt_wrap", br_cnt, 32'd0);
    check_val("miss_cnt_wrap", miss_cnt, 32'd0);
`endif

    // ---- reset mid-run: entry for 0x80 is 10 before reset ----
    @(negedge clk);
    OP_if = BEQ; pc_if = 32'h80; OP_id = NOP; Jump = 2'b01; stall = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    check_out("run_reset_outs");
    check_val("run_reset_ready", {31'd0, ready}, 32'd0);
    set_idle();
    @(negedge clk); rst_n = 1'b1;
    count_ready(n_cyc);
    check_val("reinit_len", n_cyc, 32'd64);
    begin
      vec_t r;
      r.op_if = BEQ; r.pc_if = 32'h80; r.op_id = NOP; r.pc_id = 32'h0;
      r.pred_id = 1'b0; r.taken_id = 1'b0; r.stall = 1'b0; r.jump = 2'b00;
      r.exp_pred = 1'b0; r.exp_br = 2'b00; r.exp_fl = 1'b0;
      run_vec(r, 200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
